// File: rtl/rv_pkg.sv
// Shared encodings for the memory stage: load/store func3 values,
// FSM state type and writeback error codes.
package rv_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } mem_state_t;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

endpackage

// File: rtl/mem_align.sv
// Byte-lane helper: byte enables, replicated store data, misalignment
// flag and sign/zero-extended load data from addr[1:0] and func3.
module mem_align
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      addr_lo_i,
    input  logic [2:0]      func3_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [3:0]      be_o,
    output logic [XLEN-1:0] wdata_o,
    output logic            misaligned_o,
    output logic [XLEN-1:0] ldata_o
);

    logic [XLEN-1:0] lane;

    always_comb begin
        // Shift the addressed byte/half down to bit 0.
        lane         = rdata_i >> {addr_lo_i, 3'b000};
        be_o         = 4'b1111;
        wdata_o      = rs2_i;
        misaligned_o = 1'b0;
        unique case (func3_i[1:0])
            2'b00: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {(XLEN/8){rs2_i[7:0]}};
            end
            2'b01: begin
                be_o         = 4'b0011 << addr_lo_i;
                wdata_o      = {(XLEN/16){rs2_i[15:0]}};
                misaligned_o = addr_lo_i[0];
            end
            default: misaligned_o = |addr_lo_i;
        endcase
        case (func3_i)
            F3_LB:   ldata_o = {{(XLEN-8){lane[7]}}, lane[7:0]};
            F3_LH:   ldata_o = {{(XLEN-16){lane[15]}}, lane[15:0]};
            F3_LBU:  ldata_o = {{(XLEN-8){1'b0}}, lane[7:0]};
            F3_LHU:  ldata_o = {{(XLEN-16){1'b0}}, lane[15:0]};
            default: ldata_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues loads/stores on a req/gnt/rvalid bus and
// delivers every op to writeback through one registered valid/ready slot.
module mem_stage
    import rv_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [XLEN-1:0] ex_alu_out,
    input  logic [XLEN-1:0] ex_rs2,
    input  logic [4:0]      ex_rd,
    input  logic [2:0]      ex_func3,
    input  logic            ex_mem_read,
    input  logic            ex_mem_write,
    input  logic            ex_reg_write,
    input  logic            ex_mem_to_reg,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_be,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_reg_write,
    output logic [1:0]      wb_err
);

    localparam int            CW   = $clog2(TIMEOUT + 2);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    mem_state_t      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [4:0]      rd_q, rd_d;
    logic [2:0]      f3_q, f3_d;
    logic            ld_q, ld_d, rw_q, rw_d, m2r_q, m2r_d;
    logic            req_q, req_d, we_q, we_d;
    logic [XLEN-1:0] daddr_q, daddr_d, wdata_q, wdata_d;
    logic [3:0]      be_q, be_d;
    logic            wbv_q, wbv_d, wbrw_q, wbrw_d;
    logic [4:0]      wbrd_q, wbrd_d;
    logic [XLEN-1:0] wbdata_q, wbdata_d;
    logic [1:0]      wberr_q, wberr_d;

    logic            accept, is_mem, tmo, fill, fill_rw;
    logic [4:0]      fill_rd;
    logic [XLEN-1:0] fill_data;
    logic [1:0]      fill_err;
    logic [1:0]      al_lo;
    logic [2:0]      al_f3;
    logic [3:0]      al_be;
    logic [XLEN-1:0] al_wdata, al_ldata;
    logic            al_mis;

    assign ex_ready = (state_q == S_IDLE) && (!wbv_q || wb_ready);
    assign accept   = ex_valid && ex_ready;
    assign is_mem   = ex_mem_read || ex_mem_write;

    // IDLE decodes the incoming op; later states extend the latched one.
    assign al_lo = (state_q == S_IDLE) ? ex_alu_out[1:0] : addr_q[1:0];
    assign al_f3 = (state_q == S_IDLE) ? ex_func3 : f3_q;

    mem_align #(.XLEN(XLEN)) u_align (
        .addr_lo_i    (al_lo),
        .func3_i      (al_f3),
        .rs2_i        (ex_rs2),
        .rdata_i      (dmem_rdata),
        .be_o         (al_be),
        .wdata_o      (al_wdata),
        .misaligned_o (al_mis),
        .ldata_o      (al_ldata)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        rd_d      = rd_q;
        f3_d      = f3_q;
        ld_d      = ld_q;
        rw_d      = rw_q;
        m2r_d     = m2r_q;
        req_d     = req_q;
        we_d      = we_q;
        daddr_d   = daddr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        wbv_d     = wbv_q && !wb_ready;
        wbrw_d    = wbrw_q;
        wbrd_d    = wbrd_q;
        wbdata_d  = wbdata_q;
        wberr_d   = wberr_q;
        fill      = 1'b0;
        fill_rw   = 1'b0;
        fill_rd   = rd_q;
        fill_data = addr_q;
        fill_err  = ERR_OK;
        cnt_inc   = cnt_q + 1'b1;
        // Abandon on the wait cycle that brings the count up to TIMEOUT.
        tmo       = (TIMEOUT != 0) && (cnt_inc == TMAX);
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    fill_rd   = ex_rd;
                    fill_data = ex_alu_out;
                    if (!is_mem) begin
                        fill    = 1'b1;
                        fill_rw = ex_reg_write;
                    end else if (al_mis) begin
                        fill     = 1'b1;
                        fill_err = ERR_MISALIGN;
                    end else begin
                        state_d = S_REQ;
                        cnt_d   = '0;
                        addr_d  = ex_alu_out;
                        rd_d    = ex_rd;
                        f3_d    = ex_func3;
                        ld_d    = ex_mem_read;
                        rw_d    = ex_reg_write;
                        m2r_d   = ex_mem_to_reg;
                        req_d   = 1'b1;
                        we_d    = !ex_mem_read;
                        daddr_d = {ex_alu_out[XLEN-1:2], 2'b00};
                        be_d    = al_be;
                        wdata_d = al_wdata;
                    end
                end
            end
            S_REQ: begin
                if (dmem_gnt) begin
                    req_d = 1'b0;
                    cnt_d = '0;
                    if (ld_q) begin
                        state_d = S_RESP;
                    end else begin
                        fill    = 1'b1;
                        state_d = S_IDLE;
                    end
                end else if (tmo) begin
                    req_d    = 1'b0;
                    fill     = 1'b1;
                    fill_err = ERR_TIMEOUT;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_RESP: begin
                if (dmem_rvalid) begin
                    fill      = 1'b1;
                    fill_rw   = rw_q;
                    fill_data = m2r_q ? al_ldata : addr_q;
                    state_d   = S_IDLE;
                end else if (tmo) begin
                    fill     = 1'b1;
                    fill_err = ERR_TIMEOUT;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (fill) begin
            wbv_d    = 1'b1;
            wbrw_d   = fill_rw;
            wbrd_d   = fill_rd;
            wbdata_d = fill_data;
            wberr_d  = fill_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            rd_q     <= '0;
            f3_q     <= '0;
            ld_q     <= 1'b0;
            rw_q     <= 1'b0;
            m2r_q    <= 1'b0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            daddr_q  <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            wbv_q    <= 1'b0;
            wbrw_q   <= 1'b0;
            wbrd_q   <= '0;
            wbdata_q <= '0;
            wberr_q  <= ERR_OK;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            rd_q     <= rd_d;
            f3_q     <= f3_d;
            ld_q     <= ld_d;
            rw_q     <= rw_d;
            m2r_q    <= m2r_d;
            req_q    <= req_d;
            we_q     <= we_d;
            daddr_q  <= daddr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            wbv_q    <= wbv_d;
            wbrw_q   <= wbrw_d;
            wbrd_q   <= wbrd_d;
            wbdata_q <= wbdata_d;
            wberr_q  <= wberr_d;
        end
    end

    assign dmem_req     = req_q;
    assign dmem_we      = we_q;
    assign dmem_addr    = daddr_q;
    assign dmem_wdata   = wdata_q;
    assign dmem_be      = be_q;
    assign wb_valid     = wbv_q;
    assign wb_rd        = wbrd_q;
    assign wb_data      = wbdata_q;
    assign wb_reg_write = wbrw_q;
    assign wb_err       = wberr_q;

endmodule
